// File: rtl/demod_pkg.sv
// Shared types and constants for the demodulator run scheduler.
package demod_pkg;
  localparam int N_DEMOD = 5;

  localparam logic [2:0] MT_CW  = 3'd0;
  localparam logic [2:0] MT_AM  = 3'd1;
  localparam logic [2:0] MT_FM  = 3'd2;
  localparam logic [2:0] MT_ASK = 3'd3;
  localparam logic [2:0] MT_FSK = 3'd4;
  localparam logic [2:0] MT_PSK = 3'd5;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_CLS_TO   = 2'd1;
  localparam logic [1:0] ERR_BAD_TYPE = 2'd2;
  localparam logic [1:0] ERR_DEMOD_TO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLASSIFY, ST_SETTLE, ST_MEASURE, ST_REPORT
  } state_t;

  // Demod index (type-1) of the analog paths; their rate field is meaningless.
  function automatic logic is_analog_sel(input logic [2:0] sel);
    return (sel == 3'd0) || (sel == 3'd1);
  endfunction
endpackage

// File: rtl/demod_sched.sv
// Run scheduler: classify, enable one demodulator, mask settling, latch result.
// Optional DEMOD_SCHED_RETRY_EN: first demod timeout re-runs classification once.
module demod_sched
  import demod_pkg::*;
#(
  parameter int SETTLE_CYC      = 8192,
  parameter int TIMEOUT_CYC     = 81920,
  parameter int CLS_TIMEOUT_CYC = 81920,
  parameter int FREQ_W          = 8,
  parameter int RATE_W          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  output logic                        cls_en,
  input  logic                        cls_done,
  input  logic [2:0]                  cls_type,
  output logic [N_DEMOD-1:0]          demod_en,
  input  logic [N_DEMOD-1:0]          demod_valid,
  input  logic [N_DEMOD*FREQ_W-1:0]   demod_freq,
  input  logic [N_DEMOD*RATE_W-1:0]   demod_rate,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [2:0]                  mod_type,
  output logic [FREQ_W-1:0]           freq,
  output logic [RATE_W-1:0]           rate
);
  localparam int MAX_AB  = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_MAX = (MAX_AB > CLS_TIMEOUT_CYC) ? MAX_AB : CLS_TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           sel_q;
  logic                 cls_en_q, busy_q, done_q, err_q;
  logic [N_DEMOD-1:0]   demod_en_q;
  logic [1:0]           err_code_q;
  logic [2:0]           mod_type_q;
  logic [FREQ_W-1:0]    freq_q;
  logic [RATE_W-1:0]    rate_q;
`ifdef DEMOD_SCHED_RETRY_EN
  logic                 retried_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      cls_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      demod_en_q <= '0;
      err_code_q <= ERR_NONE;
      mod_type_q <= MT_CW;
      freq_q     <= '0;
      rate_q     <= '0;
`ifdef DEMOD_SCHED_RETRY_EN
      retried_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort) begin
        state_q    <= ST_IDLE;
        cls_en_q   <= 1'b0;
        demod_en_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (start) begin
            state_q  <= ST_CLASSIFY;
            cls_en_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(CLS_TIMEOUT_CYC);
`ifdef DEMOD_SCHED_RETRY_EN
            retried_q <= 1'b0;
`endif
          end
          // Expiry is checked before cls_done so a coincident strobe is a timeout.
          ST_CLASSIFY: if (cnt_q == '0) begin
            state_q    <= ST_IDLE;
            cls_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b1;
            err_code_q <= ERR_CLS_TO;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cls_done) begin
              cls_en_q <= 1'b0;
              if (cls_type == MT_CW) begin
                state_q    <= ST_REPORT;
                done_q     <= 1'b1;
                mod_type_q <= MT_CW;
                freq_q     <= '0;
                rate_q     <= '0;
              end else if (cls_type <= MT_PSK) begin
                state_q    <= ST_SETTLE;
                sel_q      <= cls_type - 3'd1;
                demod_en_q <= N_DEMOD'(1) << (cls_type - 3'd1);
                cnt_q      <= CNT_W'(SETTLE_CYC);
              end else begin
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= ERR_BAD_TYPE;
              end
            end
          end
          ST_SETTLE: if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_MEASURE;
            cnt_q   <= CNT_W'(TIMEOUT_CYC);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
          ST_MEASURE: if (cnt_q == '0) begin
            demod_en_q <= '0;
`ifdef DEMOD_SCHED_RETRY_EN
            if (!retried_q) begin
              retried_q <= 1'b1;
              state_q   <= ST_CLASSIFY;
              cls_en_q  <= 1'b1;
              cnt_q     <= CNT_W'(CLS_TIMEOUT_CYC);
            end else begin
`else
            begin
`endif
              state_q    <= ST_IDLE;
              busy_q     <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= ERR_DEMOD_TO;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (demod_valid[sel_q]) begin
              state_q    <= ST_REPORT;
              done_q     <= 1'b1;
              mod_type_q <= sel_q + 3'd1;
              freq_q     <= demod_freq[sel_q*FREQ_W +: FREQ_W];
              rate_q     <= is_analog_sel(sel_q) ? '0 : demod_rate[sel_q*RATE_W +: RATE_W];
            end
          end
          ST_REPORT: begin
            state_q    <= ST_IDLE;
            demod_en_q <= '0;
            busy_q     <= 1'b0;
          end
          default: begin
            state_q    <= ST_IDLE;
            cls_en_q   <= 1'b0;
            demod_en_q <= '0;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cls_en   = cls_en_q;
  assign demod_en = demod_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign mod_type = mod_type_q;
  assign freq     = freq_q;
  assign rate     = rate_q;
endmodule

// File: tb/tb_demod_sched.sv
// Bench for demod_sched: directed table, randomized runs vs run-level model, abort sequences.
module tb_demod_sched;
  localparam int S   = 20;
  localparam int T   = 30;
  localparam int CLS = 25;

  logic        clk = 1'b0;
  logic        rst, start, abort, cls_done;
  logic [2:0]  cls_type;
  logic [4:0]  demod_valid;
  logic [39:0] demod_freq;
  logic [19:0] demod_rate;
  logic        cls_en, busy, done, err;
  logic [4:0]  demod_en;
  logic [1:0]  err_code;
  logic [2:0]  mod_type;
  logic [7:0]  freq;
  logic [3:0]  rate;

  demod_sched #(.SETTLE_CYC(S), .TIMEOUT_CYC(T), .CLS_TIMEOUT_CYC(CLS),
                .FREQ_W(8), .RATE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cls_en(cls_en),
    .cls_done(cls_done), .cls_type(cls_type), .demod_en(demod_en),
    .demod_valid(demod_valid), .demod_freq(demod_freq), .demod_rate(demod_rate),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .mod_type(mod_type), .freq(freq), .rate(rate));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  // Latched-result model: what the display side should be holding.
  logic [2:0] m_mt = 3'd0;
  logic [7:0] m_f = 8'd0;
  logic [3:0] m_r = 4'd0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full run. d: edge (after start) carrying cls_done; v: offset of the valid
  // pulse counted from the end of settling.
  task automatic run(input logic [2:0] ty, input int d, input int v,
                     input logic [7:0] f, input logic [3:0] r, input bit noise);
    logic [4:0] selmask, vv;
    int exp_kind, exp_at, exp_code, got_kind, got_at, lim;
    logic [2:0] got_code;
    demod_freq = {$urandom, $urandom};
    demod_rate = 20'($urandom);
    selmask = 5'd0;
    if (ty >= 3'd1 && ty <= 3'd5) begin
      selmask = 5'd1 << (ty - 3'd1);
      demod_freq[(ty-1)*8 +: 8] = f;
      demod_rate[(ty-1)*4 +: 4] = r;
    end
    exp_code = 0;
    if (d > CLS) begin
      exp_kind = 2; exp_at = CLS + 1; exp_code = 1;
    end else if (ty == 3'd0) begin
      exp_kind = 1; exp_at = d;
      m_mt = 3'd0; m_f = 8'd0; m_r = 4'd0;
    end else if (ty > 3'd5) begin
      exp_kind = 2; exp_at = d; exp_code = 2;
    end else if (v <= T) begin
      exp_kind = 1; exp_at = d + S + v;
      m_mt = ty; m_f = f; m_r = (ty <= 3'd2) ? 4'd0 : r;
    end else begin
      exp_kind = 2;
`ifdef DEMOD_SCHED_RETRY_EN
      exp_at = d + S + T + 1 + CLS + 1; exp_code = 1;
`else
      exp_at = d + S + T + 1; exp_code = 3;
`endif
    end
    lim = d + S + T + CLS + 8;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("cls_en_rise", cls_en, 1);
    chk("busy_rise", busy, 1);
    got_kind = 0; got_at = -1; got_code = 0;
    for (int k = 1; k <= lim && got_kind == 0; k++) begin
      cls_done = (k == d);
      cls_type = ty;
      vv = noise ? (5'($urandom) & ~selmask) : 5'd0;
      if (noise && k == d + 2) vv = vv | selmask;
      if (k == d + S + v) vv = vv | selmask;
      demod_valid = vv;
      tick();
      if (k == d && selmask != 0 && d <= CLS) chk("demod_en_sel", demod_en, selmask);
      if (selmask == 0) chk("demod_en_never", demod_en, 0);
      if (done || err) begin
        got_kind = done ? 1 : 2; got_at = k; got_code = err_code;
      end
    end
    cls_done = 1'b0; demod_valid = 5'd0;
    chk("end_kind", got_kind, exp_kind);
    chk("end_cycle", got_at, exp_at);
    if (exp_kind == 2) chk("err_code", got_code, exp_code);
    chk("mod_type", mod_type, m_mt);
    chk("freq", freq, m_f);
    chk("rate", rate, m_r);
    tick();
    chk("post_demod_en", demod_en, 0);
    chk("post_busy", busy, 0);
    chk("post_strobes", {done, err}, 0);
  endtask

  typedef struct {
    logic [2:0] ty; int d; int v; logic [7:0] f; logic [3:0] r; bit noise;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{3'd3, 10, 5, 8'd2, 4'd6, 1'b0};
    tbl[1] = '{3'd1, 4, 8, 8'd5, 4'd9, 1'b1};
    tbl[2] = '{3'd0, 3, 1, 8'd0, 4'd0, 1'b0};
    tbl[3] = '{3'd6, 5, 1, 8'd7, 4'd1, 1'b0};
    tbl[4] = '{3'd2, CLS + 3, 1, 8'd9, 4'd2, 1'b0};
    tbl[5] = '{3'd4, CLS, T, 8'hA5, 4'd11, 1'b1};
    tbl[6] = '{3'd5, CLS + 1, 1, 8'd3, 4'd3, 1'b0};
    tbl[7] = '{3'd5, 6, T + 1, 8'd4, 4'd4, 1'b1};
    tbl[8] = '{3'd2, 2, 1, 8'hFF, 4'd15, 1'b1};
    tbl[9] = '{3'd7, 2, 1, 8'd1, 4'd1, 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; cls_done = 1'b0; cls_type = 3'd0;
    demod_valid = 5'd0; demod_freq = '0; demod_rate = '0;
    tick(); tick();
    chk("rst_outs", {cls_en, demod_en, busy, done, err, err_code}, 0);
    chk("rst_latched", {mod_type, freq, rate}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10; i++)
      run(tbl[i].ty, tbl[i].d, tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].noise);

    for (int i = 0; i < 30; i++)
      run(3'($urandom_range(0, 7)), int'($urandom_range(1, CLS + 3)),
          int'($urandom_range(1, T + 3)), 8'($urandom), 4'($urandom), 1'($urandom));

    // start and abort together from IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_cls_en", cls_en, 0);

    // Abort during MEASURE, with a start while busy ignored along the way.
    start = 1'b1; tick(); start = 1'b0;
    tick();
    cls_done = 1'b1; cls_type = 3'd4; tick(); cls_done = 1'b0;
    chk("ab_demod_en", demod_en, 5'b01000);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_ign_en", demod_en, 5'b01000);
    chk("busy_start_ign_cls", cls_en, 0);
    for (int k = 0; k < S + 2; k++) tick();
    abort = 1'b1; demod_valid = 5'b01000; tick(); abort = 1'b0; demod_valid = 5'd0;
    chk("abort_en", {cls_en, demod_en}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {done, err}, 0);
    begin
      int seen = 0;
      for (int k = 0; k < T + 5; k++) begin
        tick();
        if (done || err || busy) seen++;
      end
      chk("abort_quiet", seen, 0);
    end
    chk("abort_hold", {mod_type, freq, rate}, {m_mt, m_f, m_r});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
